control_reg_v2: RTL and testbench

CONTROL_REG_V2 -- requirements
Module: control_reg_v2

---
 rtl/control_reg_v2.sv | 126 ++++++++++++
 tb/tb_control_reg_v2.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_reg_v2.sv
// Control register with per-bit output modes: direct, two-stage sync, self-clearing pulse.
// Latency: direct bits 1 cycle after the write, sync bits 2 cycles, pulse bits start 1 cycle after.
// Backpressure: none; every wr_en cycle is accepted and acknowledged one cycle later.
module control_reg_v2 #(
  parameter int          WIDTH      = 8,
  parameter logic [31:0] INIT_VALUE = 32'h0,
  parameter logic [31:0] SYNC_MASK  = 32'h0,
  parameter logic [31:0] PULSE_MASK = 32'h0,
  parameter int          PULSE_LEN  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_op,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  output logic [WIDTH-1:0] control,
  output logic [WIDTH-1:0] rd_data,
  output logic             pulse_busy,
  output logic             wr_ack
);

  // Counter wide enough to hold PULSE_LEN itself.
  localparam int CW = $clog2(PULSE_LEN + 1);

  // Parameter bits above WIDTH-1 are dropped here. Pulse mode wins over sync mode.
  localparam logic [WIDTH-1:0] PM         = PULSE_MASK[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SM         = SYNC_MASK[WIDTH-1:0] & ~PM;
  localparam logic [WIDTH-1:0] DM         = ~(PM | SM);
  localparam logic [WIDTH-1:0] RESET_VAL  = INIT_VALUE[WIDTH-1:0] & ~PM;
  localparam logic [CW-1:0]    CNT_LOAD   = CW'(PULSE_LEN);

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_SET    = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_TOGGLE = 2'd3
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_next;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] pulse_trig;
  logic [WIDTH-1:0] pulse_kill;
  logic [WIDTH-1:0] pulse_active;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic             ack_q;

  assign op      = op_e'(wr_op);
  assign operand = wr_data & wr_mask;

  // Next value of the stored (non-pulse) bits; pulse positions are held at zero
  // because their state lives entirely in the counters.
  always_comb begin
    reg_next = reg_q;
    if (wr_en) begin
      case (op)
        OP_WRITE:  reg_next = (reg_q & ~wr_mask) | operand;
        OP_SET:    reg_next = reg_q | operand;
        OP_CLEAR:  reg_next = reg_q & ~operand;
        OP_TOGGLE: reg_next = reg_q ^ operand;
        default:   reg_next = reg_q;
      endcase
    end
    reg_next = reg_next & ~PM;
  end

  // Any op except CLEAR with an operand bit of 1 fires (or re-arms) a pulse;
  // CLEAR with an operand bit of 1 aborts it. An operand bit of 0 never touches a counter.
  always_comb begin
    pulse_trig = '0;
    pulse_kill = '0;
    if (wr_en) begin
      if (op == OP_CLEAR) begin
        pulse_kill = operand & PM;
      end else begin
        pulse_trig = operand & PM;
      end
    end
  end

  // Register storage, sync stage and write acknowledge; reset beats any write.
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_q  <= RESET_VAL;
      sync_q <= RESET_VAL;
      ack_q  <= 1'b0;
    end else begin
      reg_q  <= reg_next;
      sync_q <= reg_q & SM;
      ack_q  <= wr_en;
    end
  end

  // Pulse counters: load on trigger (retrigger reloads with no gap), zero on CLEAR,
  // otherwise count down and stop at zero. Non-pulse positions stay at zero.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset || !PM[i]) begin
        cnt_q[i] <= '0;
      end else if (pulse_trig[i]) begin
        cnt_q[i] <= CNT_LOAD;
      end else if (pulse_kill[i]) begin
        cnt_q[i] <= '0;
      end else if (cnt_q[i] != '0) begin
        cnt_q[i] <= cnt_q[i] - CW'(1);
      end
    end
  end

  // A pulse bit is high exactly while its counter is nonzero.
  always_comb begin
    pulse_active = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pulse_active[i] = PM[i] && (cnt_q[i] != '0);
    end
  end

  assign control    = (reg_q & DM) | (sync_q & SM) | pulse_active;
  assign rd_data    = (reg_q & ~PM) | pulse_active;
  assign pulse_busy = |pulse_active;
  assign wr_ack     = ack_q;

endmodule

// File: tb/tb_control_reg_v2.sv
// Directed bench for control_reg_v2: two instances, an 8-bit one with
// sync and pulse bits and a 32-bit one with all bits direct.
module tb_control_reg_v2;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_op;
  logic [31:0] wr_data;
  logic [31:0] wr_mask;

  logic [7:0]  ctl_a;
  logic [7:0]  rd_a;
  logic        busy_a;
  logic        ack_a;
  logic [31:0] ctl_b;
  logic [31:0] rd_b;
  logic        busy_b;
  logic        ack_b;

  int total;
  int bad;

  localparam logic [1:0] OPW = 2'd0;
  localparam logic [1:0] OPS = 2'd1;
  localparam logic [1:0] OPC = 2'd2;
  localparam logic [1:0] OPT = 2'd3;

  control_reg_v2 #(
    .WIDTH(8), .INIT_VALUE(32'h5A), .SYNC_MASK(32'h01),
    .PULSE_MASK(32'h80), .PULSE_LEN(4)
  ) u_a (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_op(wr_op),
    .wr_data(wr_data[7:0]), .wr_mask(wr_mask[7:0]),
    .control(ctl_a), .rd_data(rd_a), .pulse_busy(busy_a), .wr_ack(ack_a)
  );

  control_reg_v2 #(
    .WIDTH(32), .INIT_VALUE(32'h0), .SYNC_MASK(32'h0),
    .PULSE_MASK(32'h0), .PULSE_LEN(1)
  ) u_b (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_op(wr_op),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .control(ctl_b), .rd_data(rd_b), .pulse_busy(busy_b), .wr_ack(ack_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] data, input logic [31:0] mask);
    wr_en   = 1'b1;
    wr_op   = op;
    wr_data = data;
    wr_mask = mask;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rd_a !== 8'h5A) begin bad++; $display("FAIL reset_rd_a got=%h exp=%h", rd_a, 8'h5A); end
    total++; if (ctl_a !== 8'h5A) begin bad++; $display("FAIL reset_ctl_a got=%h exp=%h", ctl_a, 8'h5A); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL reset_ack_a got=%b exp=0", ack_a); end
    total++; if (rd_b !== 32'h0) begin bad++; $display("FAIL reset_rd_b got=%h exp=0", rd_b); end
  endtask

  task automatic test_write();
    drive(OPW, 32'hFF, 32'h0F);
    step();
    wr_en = 1'b0;
    total++; if (rd_a !== 8'h5F) begin bad++; $display("FAIL write_rd got=%h exp=%h", rd_a, 8'h5F); end
    total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL write_ack got=%b exp=1", ack_a); end
    total++; if (ctl_a !== 8'h5E) begin bad++; $display("FAIL write_ctl_n1 got=%h exp=%h", ctl_a, 8'h5E); end
    step();
    total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL write_ack_once got=%b exp=0", ack_a); end
    total++; if (ctl_a !== 8'h5F) begin bad++; $display("FAIL write_ctl_n2 got=%h exp=%h", ctl_a, 8'h5F); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL write_busy got=%b exp=0", busy_a); end
  endtask

  task automatic test_sync();
    drive(OPW, 32'h00, 32'h7F);
    step();
    wr_en = 1'b0;
    step();
    total++; if (ctl_a !== 8'h00) begin bad++; $display("FAIL sync_zero got=%h exp=00", ctl_a); end
    drive(OPS, 32'h03, 32'hFF);
    step();
    wr_en = 1'b0;
    total++; if (ctl_a !== 8'h02) begin bad++; $display("FAIL sync_set_n1 got=%h exp=02", ctl_a); end
    total++; if (rd_a !== 8'h03) begin bad++; $display("FAIL sync_set_rd got=%h exp=03", rd_a); end
    step();
    total++; if (ctl_a !== 8'h03) begin bad++; $display("FAIL sync_set_n2 got=%h exp=03", ctl_a); end
    drive(OPC, 32'h03, 32'hFF);
    step();
    wr_en = 1'b0;
    total++; if (ctl_a !== 8'h01) begin bad++; $display("FAIL sync_clr_n1 got=%h exp=01", ctl_a); end
    step();
    total++; if (ctl_a !== 8'h00) begin bad++; $display("FAIL sync_clr_n2 got=%h exp=00", ctl_a); end
  endtask

  task automatic test_pulse();
    drive(OPS, 32'h80, 32'h80);
    step();
    wr_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      total++; if (ctl_a !== 8'h80) begin bad++; $display("FAIL pulse_ctl cyc=%0d got=%h exp=80", k, ctl_a); end
      total++; if (rd_a !== 8'h80) begin bad++; $display("FAIL pulse_rd cyc=%0d got=%h exp=80", k, rd_a); end
      total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL pulse_busy cyc=%0d got=%b exp=1", k, busy_a); end
      step();
    end
    total++; if (ctl_a !== 8'h00) begin bad++; $display("FAIL pulse_end_ctl got=%h exp=00", ctl_a); end
    total++; if (rd_a !== 8'h00) begin bad++; $display("FAIL pulse_end_rd got=%h exp=00", rd_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL pulse_end_busy got=%b exp=0", busy_a); end
  endtask

  task automatic test_retrigger();
    logic [7:0] exp;
    drive(OPS, 32'h80, 32'h80);
    step();
    wr_en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      exp = (k <= 6) ? 8'h80 : 8'h00;
      total++; if (ctl_a !== exp) begin bad++; $display("FAIL retrig_ctl cyc=%0d got=%h exp=%h", k, ctl_a, exp); end
      if (k == 2) drive(OPS, 32'h80, 32'h80);
      step();
      wr_en = 1'b0;
    end
  endtask

  task automatic test_clear_pulse();
    drive(OPS, 32'h80, 32'h80);
    step();
    wr_en = 1'b0;
    step();
    total++; if (ctl_a !== 8'h80) begin bad++; $display("FAIL clrp_pre got=%h exp=80", ctl_a); end
    drive(OPC, 32'h80, 32'h80);
    step();
    wr_en = 1'b0;
    total++; if (ctl_a !== 8'h00) begin bad++; $display("FAIL clrp_ctl got=%h exp=00", ctl_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL clrp_busy got=%b exp=0", busy_a); end
    // A WRITE with data 0 but mask 1 must leave a running pulse alone.
    drive(OPS, 32'h80, 32'h80);
    step();
    drive(OPW, 32'h00, 32'h80);
    step();
    wr_en = 1'b0;
    total++; if (ctl_a !== 8'h80) begin bad++; $display("FAIL wr0_c2 got=%h exp=80", ctl_a); end
    step();
    step();
    total++; if (ctl_a !== 8'h80) begin bad++; $display("FAIL wr0_c4 got=%h exp=80", ctl_a); end
    step();
    total++; if (ctl_a !== 8'h00) begin bad++; $display("FAIL wr0_c5 got=%h exp=00", ctl_a); end
  endtask

  task automatic test_toggle();
    drive(OPW, 32'h04, 32'h7F);
    step();
    drive(OPT, 32'h0C, 32'hFF);
    step();
    total++; if (rd_a !== 8'h08) begin bad++; $display("FAIL toggle1 got=%h exp=08", rd_a); end
    step();
    wr_en = 1'b0;
    total++; if (rd_a !== 8'h04) begin bad++; $display("FAIL toggle2 got=%h exp=04", rd_a); end
    total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL toggle_b2b_ack got=%b exp=1", ack_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL toggle_busy got=%b exp=0", busy_a); end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    drive(OPW, 32'hFF, 32'hFF);
    step();
    reset = 1'b0;
    wr_en = 1'b0;
    total++; if (rd_a !== 8'h5A) begin bad++; $display("FAIL rstwr_rd got=%h exp=5A", rd_a); end
    total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL rstwr_ack got=%b exp=0", ack_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rstwr_busy got=%b exp=0", busy_a); end
    step();
    total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL rstwr_ack2 got=%b exp=0", ack_a); end
    drive(OPS, 32'h80, 32'h80);
    step();
    wr_en = 1'b0;
    total++; if (ctl_a !== 8'hDA) begin bad++; $display("FAIL abort_pre got=%h exp=DA", ctl_a); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (ctl_a !== 8'h5A) begin bad++; $display("FAIL abort_ctl got=%h exp=5A", ctl_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
  endtask

  task automatic test_wide();
    do_reset();
    drive(OPW, 32'hDEADBEEF, 32'hFFFF0000);
    step();
    wr_en = 1'b0;
    total++; if (rd_b !== 32'hDEAD0000) begin bad++; $display("FAIL wide_rd got=%h exp=DEAD0000", rd_b); end
    total++; if (ctl_b !== 32'hDEAD0000) begin bad++; $display("FAIL wide_ctl got=%h exp=DEAD0000", ctl_b); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL wide_busy got=%b exp=0", busy_b); end
    total++; if (ack_b !== 1'b1) begin bad++; $display("FAIL wide_ack got=%b exp=1", ack_b); end
    // The 8-bit instance saw mask 0x00: nothing changes but the write is acknowledged.
    total++; if (rd_a !== 8'h5A) begin bad++; $display("FAIL mask0_rd got=%h exp=5A", rd_a); end
    total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL mask0_ack got=%b exp=1", ack_a); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_op   = 2'd0;
    wr_data = 32'h0;
    wr_mask = 32'h0;
    test_reset();
    test_write();
    test_sync();
    test_pulse();
    test_retrigger();
    test_clear_pulse();
    test_toggle();
    test_reset_priority();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
